// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the radix-2^2 SDF FFT core: fill, drain, collect N bins, re-arm.
// Optional feature macro FFT_FRAME_CTRL_SAT_EN: saturate (defined) or truncate (default) output bins.
module fft_frame_ctrl #(
    parameter int N            = 1024,
    parameter int N_LOG2       = 10,
    parameter int INPUT_WIDTH  = 14,
    parameter int FFT_WIDTH    = 25,
    parameter int OUTPUT_WIDTH = 25,
    parameter int TIMEOUT      = 4096
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           start_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic signed [INPUT_WIDTH-1:0]  in_re_i,
    input  logic signed [INPUT_WIDTH-1:0]  in_im_i,
    output logic                           fft_ce_o,
    output logic signed [INPUT_WIDTH-1:0]  fft_re_o,
    output logic signed [INPUT_WIDTH-1:0]  fft_im_o,
    input  logic                           fft_sync_i,
    input  logic        [N_LOG2-1:0]       fft_ctr_i,
    input  logic signed [FFT_WIDTH-1:0]    fft_re_i,
    input  logic signed [FFT_WIDTH-1:0]    fft_im_i,
    output logic                           out_valid_o,
    output logic                           out_last_o,
    output logic        [N_LOG2-1:0]       out_bin_o,
    output logic signed [OUTPUT_WIDTH-1:0] out_re_o,
    output logic signed [OUTPUT_WIDTH-1:0] out_im_o,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_underrun_o,
    output logic                           err_timeout_o
);

    localparam int CTR_W = N_LOG2 + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(N - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DRAIN,
        ST_REARM
    } state_t;

    function automatic logic [OUTPUT_WIDTH-1:0] narrow(input logic [FFT_WIDTH-1:0] x);
`ifdef FFT_FRAME_CTRL_SAT_EN
        // In range only when every bit above the output sign bit matches the input sign.
        if (x[FFT_WIDTH-1:OUTPUT_WIDTH-1] == {(FFT_WIDTH-OUTPUT_WIDTH+1){x[FFT_WIDTH-1]}})
            narrow = x[OUTPUT_WIDTH-1:0];
        else if (x[FFT_WIDTH-1])
            narrow = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
        else
            narrow = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
`else
        narrow = x[OUTPUT_WIDTH-1:0];
`endif
    endfunction

    state_t                   state_q, state_d;
    logic [CTR_W-1:0]         in_ctr_q, in_ctr_d;
    logic [CTR_W-1:0]         out_ctr_q, out_ctr_d;
    logic [TMO_W-1:0]         tmo_ctr_q, tmo_ctr_d;
    logic                     sync_seen_q, sync_seen_d;
    logic                     in_ready_q, in_ready_d;
    logic                     fft_ce_q, fft_ce_d;
    logic [INPUT_WIDTH-1:0]   fft_re_q, fft_re_d;
    logic [INPUT_WIDTH-1:0]   fft_im_q, fft_im_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;
    logic [N_LOG2-1:0]        out_bin_q, out_bin_d;
    logic [OUTPUT_WIDTH-1:0]  out_re_q, out_re_d;
    logic [OUTPUT_WIDTH-1:0]  out_im_q, out_im_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_underrun_q, err_underrun_d;
    logic                     err_timeout_q, err_timeout_d;
    logic                     capture;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the block infers a latch.
        state_d        = state_q;
        in_ctr_d       = in_ctr_q;
        out_ctr_d      = out_ctr_q;
        tmo_ctr_d      = tmo_ctr_q;
        sync_seen_d    = sync_seen_q;
        fft_re_d       = '0;
        fft_im_d       = '0;
        out_valid_d    = 1'b0;
        out_last_d     = 1'b0;
        out_bin_d      = out_bin_q;
        out_re_d       = out_re_q;
        out_im_d       = out_im_q;
        done_d         = (state_q == ST_REARM);
        err_underrun_d = err_underrun_q;
        err_timeout_d  = err_timeout_q;
        capture        = ((state_q == ST_FILL) || (state_q == ST_DRAIN)) && fft_sync_i;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d        = ST_FILL;
                    in_ctr_d       = '0;
                    out_ctr_d      = '0;
                    tmo_ctr_d      = '0;
                    sync_seen_d    = 1'b0;
                    err_underrun_d = 1'b0;
                    err_timeout_d  = 1'b0;
                end
            end
            ST_FILL: begin
                // The core is never stalled: a missing sample becomes a zero slot.
                if (in_valid_i) begin
                    fft_re_d = in_re_i;
                    fft_im_d = in_im_i;
                end else begin
                    err_underrun_d = 1'b1;
                end
                in_ctr_d = in_ctr_q + CTR_W'(1);
                if (in_ctr_q == LAST_IDX) begin
                    state_d   = ST_DRAIN;
                    tmo_ctr_d = '0;
                end
            end
            ST_DRAIN: begin
                if (!sync_seen_q && !fft_sync_i) begin
                    if (tmo_ctr_q == TMO_LAST) begin
                        err_timeout_d = 1'b1;
                        state_d       = ST_REARM;
                    end else begin
                        tmo_ctr_d = tmo_ctr_q + TMO_W'(1);
                    end
                end
            end
            ST_REARM: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (capture) begin
            sync_seen_d = 1'b1;
            out_valid_d = 1'b1;
            out_bin_d   = fft_ctr_i;
            out_re_d    = narrow(fft_re_i);
            out_im_d    = narrow(fft_im_i);
            out_ctr_d   = out_ctr_q + CTR_W'(1);
            if (out_ctr_q == LAST_IDX) begin
                out_last_d = 1'b1;
                state_d    = ST_REARM;
            end
        end

        // Registered status follows the state being entered; ce drops for the REARM cycle.
        in_ready_d = (state_d == ST_FILL);
        busy_d     = (state_d != ST_IDLE);
        fft_ce_d   = ((state_q == ST_FILL) || (state_q == ST_DRAIN)) && (state_d != ST_REARM);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q        <= ST_IDLE;
            in_ctr_q       <= '0;
            out_ctr_q      <= '0;
            tmo_ctr_q      <= '0;
            sync_seen_q    <= 1'b0;
            in_ready_q     <= 1'b0;
            fft_ce_q       <= 1'b0;
            fft_re_q       <= '0;
            fft_im_q       <= '0;
            out_valid_q    <= 1'b0;
            out_last_q     <= 1'b0;
            out_bin_q      <= '0;
            out_re_q       <= '0;
            out_im_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_underrun_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            in_ctr_q       <= in_ctr_d;
            out_ctr_q      <= out_ctr_d;
            tmo_ctr_q      <= tmo_ctr_d;
            sync_seen_q    <= sync_seen_d;
            in_ready_q     <= in_ready_d;
            fft_ce_q       <= fft_ce_d;
            fft_re_q       <= fft_re_d;
            fft_im_q       <= fft_im_d;
            out_valid_q    <= out_valid_d;
            out_last_q     <= out_last_d;
            out_bin_q      <= out_bin_d;
            out_re_q       <= out_re_d;
            out_im_q       <= out_im_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_underrun_q <= err_underrun_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    assign in_ready_o     = in_ready_q;
    assign fft_ce_o       = fft_ce_q;
    assign fft_re_o       = fft_re_q;
    assign fft_im_o       = fft_im_q;
    assign out_valid_o    = out_valid_q;
    assign out_last_o     = out_last_q;
    assign out_bin_o      = out_bin_q;
    assign out_re_o       = out_re_q;
    assign out_im_o       = out_im_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_underrun_o = err_underrun_q;
    assign err_timeout_o  = err_timeout_q;

endmodule
